// File: rtl/rom_fetch_arbiter.sv
// rom_fetch_arbiter
// Shares the single external ROM read port between the 68000 program ROM
// window and the Z80 sound ROM window. Each requester keeps a one-entry
// cache (tag, 16-bit word, hit flag). The valid outputs are combinational,
// so a re-selected cached address is valid in the same cycle as its chip
// select. Misses are fetched one at a time. When both requesters miss
// together, the grant alternates between them.

module rom_fetch_arbiter #(
   parameter logic [23:0] M68K_BASE = 24'h000000,
   parameter logic [23:0] Z80_BASE  = 24'h020000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        m68k_rom_cs,
   input  logic [15:0] m68k_addr,
   output logic [15:0] m68k_rom_data,
   output logic        m68k_rom_valid,
   input  logic        z80_rom_cs,
   input  logic [15:0] z80_addr,
   output logic [7:0]  z80_rom_data,
   output logic        z80_rom_valid,
   output logic        rom_req,
   output logic [23:0] rom_addr,
   input  logic        rom_ack,
   input  logic [15:0] rom_data
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   localparam logic OWN_M68K = 1'b0;
   localparam logic OWN_Z80  = 1'b1;

   // Arbiter state
   logic [0:0]  state;
   logic        owner;
   logic        last_grant;
   logic [15:0] req_tag;

   // 68000 cache entry (tag is the CPU word address)
   logic [15:0] m68k_tag;
   logic [15:0] m68k_data;
   logic        m68k_hit;

   // Z80 cache entry (tag is the byte address with bit 0 dropped)
   logic [14:0] z80_tag;
   logic [15:0] z80_data;
   logic        z80_hit;

   // Decode helpers
   logic        m68k_pending;
   logic        z80_pending;
   logic        grant_z80;
   logic [23:0] m68k_xlat;
   logic [23:0] z80_xlat;

   // Cache lookup: valid and data are pure functions of the current inputs and
   // the cache registers; they are forced low while reset is held.
   always_comb begin
      // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
      m68k_rom_valid = 1'b0;
      z80_rom_valid  = 1'b0;
      m68k_rom_data  = '0;
      z80_rom_data   = '0;
      if (!reset) begin
         m68k_rom_valid = m68k_hit && m68k_rom_cs && (m68k_addr == m68k_tag);
         z80_rom_valid  = z80_hit && z80_rom_cs && (z80_addr[15:1] == z80_tag);
         m68k_rom_data  = m68k_data;
         // Big-endian word: the even byte is in the upper half.
         z80_rom_data   = z80_addr[0] ? z80_data[7:0] : z80_data[15:8];
      end
   end

   // Arbitration: find the pending requesters and choose one. On a tie, the
   // requester that did not receive the previous grant wins.
   always_comb begin
      m68k_pending = m68k_rom_cs && !m68k_rom_valid;
      z80_pending  = z80_rom_cs && !z80_rom_valid;
      grant_z80    = 1'b0;
      if (m68k_pending && z80_pending) begin
         grant_z80 = (last_grant == OWN_M68K);
      end else begin
         grant_z80 = z80_pending;
      end
      // Byte addresses in the external ROM space. The add wraps at 24 bits.
      m68k_xlat = M68K_BASE + {7'b0, m68k_addr, 1'b0};
      z80_xlat  = Z80_BASE + {8'b0, z80_addr[15:1], 1'b0};
   end

   // Fetch sequencer: grant in IDLE, hold the request in BUSY until ack,
   // then fill the owner's cache entry.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state      <= ST_IDLE;
         owner      <= OWN_M68K;
         last_grant <= OWN_Z80;
         req_tag    <= '0;
         rom_req    <= 1'b0;
         rom_addr   <= '0;
         // NOTE: the cache data registers are cleared on reset so that the data outputs read 0 after reset.
         m68k_tag   <= '0;
         m68k_data  <= '0;
         m68k_hit   <= 1'b0;
         z80_tag    <= '0;
         z80_data   <= '0;
         z80_hit    <= 1'b0;
      end else begin
         // NOTE: all state uses non-blocking assignments, so every register samples pre-edge values.
         case (state)
            ST_IDLE: begin
               // A stray rom_ack in IDLE is ignored.
               if (m68k_pending || z80_pending) begin
                  owner      <= grant_z80;
                  last_grant <= grant_z80;
                  rom_req    <= 1'b1;
                  state      <= ST_BUSY;
                  if (grant_z80) begin
                     req_tag  <= {1'b0, z80_addr[15:1]};
                     rom_addr <= z80_xlat;
                     z80_hit  <= 1'b0;
                  end else begin
                     req_tag  <= m68k_addr;
                     rom_addr <= m68k_xlat;
                     m68k_hit <= 1'b0;
                  end
               end
            end
            ST_BUSY: begin
               // rom_addr and req_tag stay frozen, whatever the CPUs do meanwhile.
               if (rom_ack) begin
                  rom_req <= 1'b0;
                  state   <= ST_IDLE;
                  if (owner == OWN_Z80) begin
                     z80_data <= rom_data;
                     z80_tag  <= req_tag[14:0];
                     z80_hit  <= 1'b1;
                  end else begin
                     m68k_data <= rom_data;
                     m68k_tag  <= req_tag;
                     m68k_hit  <= 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// tb_rom_fetch_arbiter
// Directed scenarios for the arbiter's defined behaviours, followed by a
// randomized run. In the randomized run, the bench acts as the ROM bridge
// and checks the DUT against a transaction-level model: a ROM image
// function, per-CPU cached addresses and an alternating tie winner.

module tb_rom_fetch_arbiter;

   localparam logic [23:0] M68K_BASE = 24'h000000;
   localparam logic [23:0] Z80_BASE  = 24'h020000;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        m68k_rom_cs;
   logic [15:0] m68k_addr;
   logic [15:0] m68k_rom_data;
   logic        m68k_rom_valid;
   logic        z80_rom_cs;
   logic [15:0] z80_addr;
   logic [7:0]  z80_rom_data;
   logic        z80_rom_valid;
   logic        rom_req;
   logic [23:0] rom_addr;
   logic        rom_ack;
   logic [15:0] rom_data;

   int n_checks = 0;
   int n_pass   = 0;

   rom_fetch_arbiter #(
      .M68K_BASE(M68K_BASE),
      .Z80_BASE (Z80_BASE)
   ) dut (
      .clk_sys       (clk_sys),
      .reset         (reset),
      .m68k_rom_cs   (m68k_rom_cs),
      .m68k_addr     (m68k_addr),
      .m68k_rom_data (m68k_rom_data),
      .m68k_rom_valid(m68k_rom_valid),
      .z80_rom_cs    (z80_rom_cs),
      .z80_addr      (z80_addr),
      .z80_rom_data  (z80_rom_data),
      .z80_rom_valid (z80_rom_valid),
      .rom_req       (rom_req),
      .rom_addr      (rom_addr),
      .rom_ack       (rom_ack),
      .rom_data      (rom_data)
   );

   always #5 clk_sys = ~clk_sys;

   // Move to 1 time unit after the next rising edge, where inputs are driven.
   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   // ROM image content for a byte address.
   function automatic logic [15:0] rom_word(input logic [23:0] a);
      return (a[16:1] * 16'd40503) ^ {9'd0, a[23:17]};
   endfunction

   function automatic logic [23:0] m_xlat(input logic [15:0] a);
      return M68K_BASE + {7'b0, a, 1'b0};
   endfunction

   function automatic logic [23:0] z_xlat(input logic [15:0] a);
      return Z80_BASE + {8'b0, a[15:1], 1'b0};
   endfunction

   task automatic apply_reset();
      reset = 1'b1; m68k_rom_cs = 1'b0; z80_rom_cs = 1'b0; rom_ack = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; rom_ack = 1'b0; rom_data = 16'h0000;
      m68k_rom_cs = 1'b1; m68k_addr = 16'h0000; z80_rom_cs = 1'b1; z80_addr = 16'h0000;
      #1;
      n_checks++; if (m68k_rom_valid !== 1'b0) $display("FAIL rst_m68k_valid: got %b want 0", m68k_rom_valid); else n_pass++;
      n_checks++; if (z80_rom_valid !== 1'b0) $display("FAIL rst_z80_valid: got %b want 0", z80_rom_valid); else n_pass++;
      n_checks++; if (m68k_rom_data !== 16'h0000) $display("FAIL rst_m68k_data: got %h want 0000", m68k_rom_data); else n_pass++;
      n_checks++; if (z80_rom_data !== 8'h00) $display("FAIL rst_z80_data: got %h want 00", z80_rom_data); else n_pass++;
      step();
      n_checks++; if (rom_req !== 1'b0) $display("FAIL rst_req: got %b want 0", rom_req); else n_pass++;
      n_checks++; if (rom_addr !== 24'h000000) $display("FAIL rst_addr: got %h want 000000", rom_addr); else n_pass++;
      step();
      reset = 1'b0; m68k_rom_cs = 1'b0; z80_rom_cs = 1'b0;
      #1;
      n_checks++; if (m68k_rom_data !== 16'h0000) $display("FAIL post_rst_m68k_data: got %h want 0000", m68k_rom_data); else n_pass++;
      n_checks++; if (rom_req !== 1'b0) $display("FAIL post_rst_req: got %b want 0", rom_req); else n_pass++;
   endtask

   task automatic test_m68k_miss_hit();
      step();
      m68k_rom_cs = 1'b1; m68k_addr = 16'h0123;
      #1;
      n_checks++; if (m68k_rom_valid !== 1'b0) $display("FAIL m68k_miss_valid: got %b want 0", m68k_rom_valid); else n_pass++;
      step();
      n_checks++; if (rom_req !== 1'b1) $display("FAIL m68k_req_rise: got %b want 1", rom_req); else n_pass++;
      n_checks++; if (rom_addr !== 24'h000246) $display("FAIL m68k_rom_addr: got %h want 000246", rom_addr); else n_pass++;
      step();
      step();
      n_checks++; if (rom_req !== 1'b1) $display("FAIL m68k_req_held: got %b want 1", rom_req); else n_pass++;
      step();
      rom_ack = 1'b1; rom_data = 16'hBEEF;
      #1;
      n_checks++; if (m68k_rom_valid !== 1'b0) $display("FAIL m68k_valid_in_ack: got %b want 0", m68k_rom_valid); else n_pass++;
      step();
      rom_ack = 1'b0;
      #1;
      n_checks++; if (m68k_rom_valid !== 1'b1) $display("FAIL m68k_valid_after_ack: got %b want 1", m68k_rom_valid); else n_pass++;
      n_checks++; if (m68k_rom_data !== 16'hBEEF) $display("FAIL m68k_data: got %h want beef", m68k_rom_data); else n_pass++;
      n_checks++; if (rom_req !== 1'b0) $display("FAIL m68k_req_drop: got %b want 0", rom_req); else n_pass++;
      m68k_rom_cs = 1'b0;
      #1;
      n_checks++; if (m68k_rom_valid !== 1'b0) $display("FAIL m68k_valid_cs_drop: got %b want 0", m68k_rom_valid); else n_pass++;
      step();
      step();
      m68k_rom_cs = 1'b1;
      #1;
      n_checks++; if (m68k_rom_valid !== 1'b1) $display("FAIL m68k_rehit_valid: got %b want 1", m68k_rom_valid); else n_pass++;
      n_checks++; if (m68k_rom_data !== 16'hBEEF) $display("FAIL m68k_rehit_data: got %h want beef", m68k_rom_data); else n_pass++;
      step();
      n_checks++; if (rom_req !== 1'b0) $display("FAIL m68k_rehit_no_req: got %b want 0", rom_req); else n_pass++;
      m68k_rom_cs = 1'b0;
   endtask

   task automatic test_z80_byte_select();
      step();
      z80_rom_cs = 1'b1; z80_addr = 16'h1235;
      step();
      n_checks++; if (rom_addr !== 24'h021234) $display("FAIL z80_rom_addr: got %h want 021234", rom_addr); else n_pass++;
      // Ack in the first request cycle gives the minimum 2-cycle miss latency.
      rom_ack = 1'b1; rom_data = 16'hA55A;
      step();
      rom_ack = 1'b0;
      #1;
      n_checks++; if (z80_rom_valid !== 1'b1) $display("FAIL z80_valid: got %b want 1", z80_rom_valid); else n_pass++;
      n_checks++; if (z80_rom_data !== 8'h5A) $display("FAIL z80_odd_byte: got %h want 5a", z80_rom_data); else n_pass++;
      z80_addr = 16'h1234;
      #1;
      n_checks++; if (z80_rom_valid !== 1'b1) $display("FAIL z80_even_hit: got %b want 1", z80_rom_valid); else n_pass++;
      n_checks++; if (z80_rom_data !== 8'hA5) $display("FAIL z80_even_byte: got %h want a5", z80_rom_data); else n_pass++;
      step();
      n_checks++; if (rom_req !== 1'b0) $display("FAIL z80_hit_no_req: got %b want 0", rom_req); else n_pass++;
      z80_rom_cs = 1'b0;
      #1;
      n_checks++; if (z80_rom_valid !== 1'b0) $display("FAIL z80_valid_cs_drop: got %b want 0", z80_rom_valid); else n_pass++;
   endtask

   task automatic test_simultaneous();
      apply_reset();
      m68k_rom_cs = 1'b1; m68k_addr = 16'h0200; z80_rom_cs = 1'b1; z80_addr = 16'h0400;
      step();
      n_checks++; if (rom_addr !== 24'h000400) $display("FAIL tie1_first_m68k: got %h want 000400", rom_addr); else n_pass++;
      rom_ack = 1'b1; rom_data = 16'h1111;
      step();
      rom_ack = 1'b0;
      #1;
      n_checks++; if (m68k_rom_valid !== 1'b1 || z80_rom_valid !== 1'b0) $display("FAIL tie1_valids: got m68k=%b z80=%b want 1/0", m68k_rom_valid, z80_rom_valid); else n_pass++;
      step();
      n_checks++; if (rom_req !== 1'b1 || rom_addr !== 24'h020400) $display("FAIL tie1_second_z80: got req=%b addr=%h want 1/020400", rom_req, rom_addr); else n_pass++;
      rom_ack = 1'b1; rom_data = 16'h2222;
      step();
      rom_ack = 1'b0;
      #1;
      n_checks++; if (z80_rom_valid !== 1'b1 || z80_rom_data !== 8'h22) $display("FAIL tie1_z80_fill: got valid=%b data=%h want 1/22", z80_rom_valid, z80_rom_data); else n_pass++;
      // A solo 68000 fetch makes the 68000 the latest grant, so the Z80 wins the next tie.
      z80_rom_cs = 1'b0; m68k_addr = 16'h0202;
      step();
      n_checks++; if (rom_addr !== 24'h000404) $display("FAIL solo_m68k_addr: got %h want 000404", rom_addr); else n_pass++;
      rom_ack = 1'b1; rom_data = 16'h3333;
      step();
      rom_ack = 1'b0;
      m68k_addr = 16'h0204; z80_rom_cs = 1'b1; z80_addr = 16'h0402;
      step();
      n_checks++; if (rom_req !== 1'b1 || rom_addr !== 24'h020402) $display("FAIL tie2_first_z80: got req=%b addr=%h want 1/020402", rom_req, rom_addr); else n_pass++;
      rom_ack = 1'b1; rom_data = 16'h4444;
      step();
      rom_ack = 1'b0;
      step();
      n_checks++; if (rom_req !== 1'b1 || rom_addr !== 24'h000408) $display("FAIL tie2_second_m68k: got req=%b addr=%h want 1/000408", rom_req, rom_addr); else n_pass++;
      rom_ack = 1'b1; rom_data = 16'h5555;
      step();
      rom_ack = 1'b0;
      #1;
      n_checks++; if (m68k_rom_data !== 16'h5555 || z80_rom_data !== 8'h44) $display("FAIL tie2_fill: got m68k=%h z80=%h want 5555/44", m68k_rom_data, z80_rom_data); else n_pass++;
      m68k_rom_cs = 1'b0; z80_rom_cs = 1'b0;
   endtask

   task automatic test_addr_change_busy();
      step();
      m68k_rom_cs = 1'b1; m68k_addr = 16'h0010;
      step();
      n_checks++; if (rom_addr !== 24'h000020) $display("FAIL chg_first_addr: got %h want 000020", rom_addr); else n_pass++;
      m68k_addr = 16'h0011;
      step();
      step();
      n_checks++; if (rom_req !== 1'b1 || rom_addr !== 24'h000020) $display("FAIL chg_addr_held: got req=%b addr=%h want 1/000020", rom_req, rom_addr); else n_pass++;
      rom_ack = 1'b1; rom_data = 16'h3C3C;
      step();
      rom_ack = 1'b0;
      #1;
      n_checks++; if (m68k_rom_valid !== 1'b0) $display("FAIL chg_valid_low: got %b want 0", m68k_rom_valid); else n_pass++;
      n_checks++; if (rom_req !== 1'b0) $display("FAIL chg_req_gap: got %b want 0", rom_req); else n_pass++;
      step();
      n_checks++; if (rom_req !== 1'b1 || rom_addr !== 24'h000022) $display("FAIL chg_refetch: got req=%b addr=%h want 1/000022", rom_req, rom_addr); else n_pass++;
      rom_ack = 1'b1; rom_data = 16'h4B4B;
      step();
      rom_ack = 1'b0;
      #1;
      n_checks++; if (m68k_rom_valid !== 1'b1 || m68k_rom_data !== 16'h4B4B) $display("FAIL chg_fill: got valid=%b data=%h want 1/4b4b", m68k_rom_valid, m68k_rom_data); else n_pass++;
      m68k_addr = 16'h0010;
      #1;
      n_checks++; if (m68k_rom_valid !== 1'b0) $display("FAIL chg_old_addr_evicted: got %b want 0", m68k_rom_valid); else n_pass++;
      m68k_rom_cs = 1'b0;
   endtask

   task automatic test_reset_mid_fetch();
      step();
      m68k_rom_cs = 1'b1; m68k_addr = 16'h0300;
      step();
      n_checks++; if (rom_req !== 1'b1) $display("FAIL rmf_req_before: got %b want 1", rom_req); else n_pass++;
      reset = 1'b1; m68k_rom_cs = 1'b0;
      step();
      n_checks++; if (rom_req !== 1'b0) $display("FAIL rmf_req_after_reset: got %b want 0", rom_req); else n_pass++;
      reset = 1'b0;
      step();
      rom_ack = 1'b1; rom_data = 16'h5555;
      step();
      rom_ack = 1'b0;
      #1;
      n_checks++; if (rom_req !== 1'b0) $display("FAIL rmf_req_late_ack: got %b want 0", rom_req); else n_pass++;
      n_checks++; if (m68k_rom_data !== 16'h0000 || z80_rom_data !== 8'h00) $display("FAIL rmf_no_fill: got m68k=%h z80=%h want 0000/00", m68k_rom_data, z80_rom_data); else n_pass++;
      m68k_rom_cs = 1'b1;
      #1;
      n_checks++; if (m68k_rom_valid !== 1'b0 || z80_rom_valid !== 1'b0) $display("FAIL rmf_valids: got m68k=%b z80=%b want 0/0", m68k_rom_valid, z80_rom_valid); else n_pass++;
      step();
      n_checks++; if (rom_addr !== 24'h000600) $display("FAIL rmf_refetch_addr: got %h want 000600", rom_addr); else n_pass++;
      rom_ack = 1'b1; rom_data = 16'h6666;
      step();
      rom_ack = 1'b0;
      m68k_rom_cs = 1'b0;
   endtask

   task automatic test_stale_ack();
      step();
      rom_ack = 1'b1; rom_data = 16'hFFFF;
      step();
      rom_ack = 1'b0;
      #1;
      n_checks++; if (rom_req !== 1'b0) $display("FAIL stale_req: got %b want 0", rom_req); else n_pass++;
      m68k_rom_cs = 1'b1; m68k_addr = 16'h0300;
      #1;
      n_checks++; if (m68k_rom_valid !== 1'b1 || m68k_rom_data !== 16'h6666) $display("FAIL stale_m68k_kept: got valid=%b data=%h want 1/6666", m68k_rom_valid, m68k_rom_data); else n_pass++;
      z80_rom_cs = 1'b1; z80_addr = 16'h0000;
      #1;
      n_checks++; if (z80_rom_valid !== 1'b0 || z80_rom_data !== 8'h00) $display("FAIL stale_z80_kept: got valid=%b data=%h want 0/00", z80_rom_valid, z80_rom_data); else n_pass++;
      z80_rom_cs = 1'b0;
      step();
      n_checks++; if (rom_req !== 1'b0) $display("FAIL stale_no_fetch: got %b want 0", rom_req); else n_pass++;
      m68k_rom_cs = 1'b0;
   endtask

   task automatic test_random();
      logic        model_hit [2];
      logic [15:0] model_tag [2];
      logic        model_last;
      logic [15:0] m_pool [4];
      logic [15:0] z_pool [5];
      m_pool = '{16'h0100, 16'h0101, 16'h7FFF, 16'hFFFF};
      z_pool = '{16'h0000, 16'h0001, 16'h1234, 16'h1235, 16'hFFFF};
      apply_reset();
      model_hit[0] = 1'b0; model_hit[1] = 1'b0;
      model_tag[0] = '0;   model_tag[1] = '0;
      model_last = 1'b1;  // after reset the Z80 counts as the latest grant
      for (int it = 0; it < 60; it++) begin
         logic        m_cs, z_cs, pend_m, pend_z, owner, in_flight, just_acked, done;
         logic [15:0] m_a, z_a, own_tag, w;
         logic [23:0] exp_addr;
         int          delay;
         m_cs = ($urandom_range(0, 3) != 0);
         z_cs = ($urandom_range(0, 3) != 0);
         m_a  = m_pool[$urandom_range(0, 3)];
         z_a  = z_pool[$urandom_range(0, 4)];
         in_flight = 1'b0; just_acked = 1'b0; done = 1'b0; delay = 0; owner = 1'b0; own_tag = '0;
         step();
         m68k_rom_cs = m_cs; m68k_addr = m_a; z80_rom_cs = z_cs; z80_addr = z_a; rom_ack = 1'b0;
         #1;
         pend_m = m_cs && !(model_hit[0] && model_tag[0] == m_a);
         pend_z = z_cs && !(model_hit[1] && model_tag[1] == {1'b0, z_a[15:1]});
         n_checks++; if (m68k_rom_valid !== (m_cs && !pend_m)) $display("FAIL rnd_m68k_hit it=%0d: got %b want %b", it, m68k_rom_valid, m_cs && !pend_m); else n_pass++;
         n_checks++; if (z80_rom_valid !== (z_cs && !pend_z)) $display("FAIL rnd_z80_hit it=%0d: got %b want %b", it, z80_rom_valid, z_cs && !pend_z); else n_pass++;
         for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            step();
            rom_ack = 1'b0;
            pend_m = m_cs && !(model_hit[0] && model_tag[0] == m_a);
            pend_z = z_cs && !(model_hit[1] && model_tag[1] == {1'b0, z_a[15:1]});
            if (just_acked) begin
               n_checks++; if (rom_req !== 1'b0) $display("FAIL rnd_req_gap it=%0d: got %b want 0", it, rom_req); else n_pass++;
               just_acked = 1'b0;
            end else if (!in_flight && rom_req === 1'b1) begin
               n_checks++; if (!pend_m && !pend_z) $display("FAIL rnd_spurious_req it=%0d: got req=1 want 0", it); else n_pass++;
               owner    = (pend_m && pend_z) ? !model_last : pend_z;
               exp_addr = owner ? z_xlat(z_a) : m_xlat(m_a);
               own_tag  = owner ? {1'b0, z_a[15:1]} : m_a;
               n_checks++; if (rom_addr !== exp_addr) $display("FAIL rnd_grant_addr it=%0d: got %h want %h", it, rom_addr, exp_addr); else n_pass++;
               model_last = owner;
               model_hit[owner] = 1'b0;
               in_flight = 1'b1;
               delay = $urandom_range(0, 3);
            end
            if (in_flight) begin
               if (delay == 0) begin
                  rom_ack = 1'b1;
                  rom_data = rom_word(rom_addr);
                  model_hit[owner] = 1'b1;
                  model_tag[owner] = own_tag;
                  in_flight = 1'b0;
                  just_acked = 1'b1;
               end else begin
                  delay--;
               end
            end
            pend_m = m_cs && !(model_hit[0] && model_tag[0] == m_a);
            pend_z = z_cs && !(model_hit[1] && model_tag[1] == {1'b0, z_a[15:1]});
            done = !in_flight && !just_acked && !pend_m && !pend_z;
         end
         n_checks++; if (!done) $display("FAIL rnd_timeout it=%0d: got not-done want done within 40 cycles", it); else n_pass++;
         #1;
         w = rom_word(m_xlat(m_a));
         n_checks++; if (m68k_rom_valid !== m_cs) $display("FAIL rnd_m68k_valid it=%0d: got %b want %b", it, m68k_rom_valid, m_cs); else n_pass++;
         if (m_cs) begin
            n_checks++; if (m68k_rom_data !== w) $display("FAIL rnd_m68k_data it=%0d: got %h want %h", it, m68k_rom_data, w); else n_pass++;
         end
         w = rom_word(z_xlat(z_a));
         n_checks++; if (z80_rom_valid !== z_cs) $display("FAIL rnd_z80_valid it=%0d: got %b want %b", it, z80_rom_valid, z_cs); else n_pass++;
         if (z_cs) begin
            n_checks++; if (z80_rom_data !== (z_a[0] ? w[7:0] : w[15:8])) $display("FAIL rnd_z80_data it=%0d: got %h want %h", it, z80_rom_data, z_a[0] ? w[7:0] : w[15:8]); else n_pass++;
         end
         step();
         n_checks++; if (rom_req !== 1'b0) $display("FAIL rnd_idle_req it=%0d: got %b want 0", it, rom_req); else n_pass++;
         if ($urandom_range(0, 2) == 0) begin
            m68k_rom_cs = 1'b0; z80_rom_cs = 1'b0;
         end
      end
      m68k_rom_cs = 1'b0; z80_rom_cs = 1'b0; rom_ack = 1'b0;
   endtask

   initial begin
      test_reset();
      test_m68k_miss_hit();
      test_z80_byte_select();
      test_simultaneous();
      test_addr_change_busy();
      test_reset_mid_fetch();
      test_stale_ack();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1);
   end

endmodule
